rst_gen: RTL and testbench

- Reset sequencer directly downstream of the PLL wrapper.
- Consumes the PLL lock indication and a board push-button reset, and drives the PLL's reset input.
- Produces a clean, stretched, active-low reset for the CPU core and peripherals in the PLL output clock domain.
- Recovers automatically from lock loss and counts lock-loss events for debug (LED/UART readout).

---
 rtl/rst_gen_pkg.sv | 27 ++
 rtl/sync2.sv | 31 +++
 rtl/rst_gen.sv | 143 ++++++++++++++
 tb/tb_rst_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rst_gen_pkg : state encoding and counter sizing helper for the reset sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package rst_gen_pkg;

  typedef enum logic [1:0] {
    S_PLLRST    = 2'b00,
    S_WAIT_LOCK = 2'b01,
    S_HOLD      = 2'b10,
    S_RUN       = 2'b11
  } state_e;

  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync2 : two-flop synchronizer with selectable reset value
// Rev 1.0
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/rst_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rst_gen : PLL reset sequencer with lock qualification, button debounce and lock-loss count
// Rev 1.0
// ---------------------------------------------------------------------------
module rst_gen
  import rst_gen_pkg::*;
#(
  parameter int PLL_RST_CYCLES  = 4,
  parameter int LOCK_CYCLES     = 8,
  parameter int LOCK_TIMEOUT    = 64,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int USE_LOCK        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       btn_rst_n,
  output logic       pll_reset,
  output logic       cpu_rst_n,
  output logic [1:0] rst_state,
  output logic [7:0] lock_lost_cnt
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_CYCLES, LOCK_TIMEOUT,
                                HOLD_CYCLES, DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic          lock_s;
  logic          btn_s;
  logic          btn_req;
  logic [CW-1:0] deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lk_q, lk_d;
  logic [7:0]    lost_q, lost_d;
  state_e        state_q, state_d;
  logic          pll_reset_q, pll_reset_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;

  generate
    if (USE_LOCK != 0) begin : g_lock_sync
      sync2 #(.RST_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
      );
    end else begin : g_lock_tie
      logic unused_pll_lock;
      assign unused_pll_lock = pll_lock;
      assign lock_s          = 1'b1;
    end
  endgenerate

  sync2 #(.RST_VAL(1'b1)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_rst_n),
    .q_o   (btn_s)
  );

  // Debounce counter parks at its last value while the button stays low.
  always_comb begin
    deb_d   = '0;
    btn_req = 1'b0;
    if (!btn_s) begin
      deb_d   = (deb_q == DEB_LAST) ? deb_q : deb_q + ONE;
      btn_req = (deb_q == DEB_LAST);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    lk_d    = '0;
    lost_d  = lost_q;
    case (state_q)
      S_PLLRST: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        cnt_d = cnt_q + ONE;
        lk_d  = lock_s ? lk_q + ONE : '0;
        if (lock_s && lk_q == LOCK_LAST) state_d = S_HOLD;
        else if (cnt_q == TMO_LAST)      state_d = S_PLLRST;
      end
      S_HOLD: begin
        cnt_d = btn_s ? cnt_q + ONE : '0;
        if (!lock_s)                          state_d = S_PLLRST;
        else if (btn_s && cnt_q == HOLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_PLLRST;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (btn_req) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_PLLRST;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      lk_d  = '0;
    end
    pll_reset_d = (state_d == S_PLLRST);
    cpu_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PLLRST;
      deb_q       <= '0;
      cnt_q       <= '0;
      lk_q        <= '0;
      lost_q      <= '0;
      pll_reset_q <= 1'b1;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      lk_q        <= lk_d;
      lost_q      <= lost_d;
      pll_reset_q <= pll_reset_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign rst_state     = state_q;
  assign lock_lost_cnt = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rst_gen : scoreboard bench for rst_gen against a cycle-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rst_gen;

  localparam int PLLR  = 4;
  localparam int LOCKC = 8;
  localparam int TMO   = 64;
  localparam int HOLDC = 16;
  localparam int DEB   = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       pll_lock  = 1'b0;
  logic       btn_rst_n = 1'b1;
  logic       pll_reset;
  logic       cpu_rst_n;
  logic [1:0] rst_state;
  logic [7:0] lock_lost_cnt;

  always #5 clk = ~clk;

  rst_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .btn_rst_n     (btn_rst_n),
    .pll_reset     (pll_reset),
    .cpu_rst_n     (cpu_rst_n),
    .rst_state     (rst_state),
    .lock_lost_cnt (lock_lost_cnt)
  );

  typedef struct packed {
    logic       pr;
    logic       cr;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: states as integers 0..3, time-in-state and run lengths
  // of the synchronized inputs, all counted from the rules directly.
  int         m_st   = 0;
  int         m_t    = 0;
  int         m_lrun = 0;
  int         m_hrun = 0;
  int         m_blow = 0;
  int         m_lost = 0;
  int         m_nxt  = 0;
  logic [1:0] m_lk   = 2'b00;
  logic [1:0] m_bt   = 2'b11;
  logic       m_ls, m_bs;
  exp_t       m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_t = 0; m_lrun = 0; m_hrun = 0; m_blow = 0; m_lost = 0;
      m_lk = 2'b00; m_bt = 2'b11;
      sb_q.delete();
    end else begin
      m_ls   = m_lk[1];
      m_bs   = m_bt[1];
      m_blow = m_bs ? 0 : m_blow + 1;
      m_nxt  = m_st;
      m_t    = m_t + 1;
      case (m_st)
        0: if (m_t == PLLR) m_nxt = 1;
        1: begin
          m_lrun = m_ls ? m_lrun + 1 : 0;
          if (m_lrun == LOCKC)  m_nxt = 2;
          else if (m_t == TMO)  m_nxt = 0;
        end
        2: begin
          m_hrun = m_bs ? m_hrun + 1 : 0;
          if (!m_ls)                m_nxt = 0;
          else if (m_hrun == HOLDC) m_nxt = 3;
        end
        default: begin
          if (!m_ls) begin
            m_nxt = 0;
            if (m_lost < 255) m_lost = m_lost + 1;
          end else if (m_blow >= DEB) begin
            m_nxt = 2;
          end
        end
      endcase
      if (m_nxt != m_st) begin
        m_t = 0; m_lrun = 0; m_hrun = 0;
      end
      m_st = m_nxt;
      m_lk = {m_lk[0], pll_lock};
      m_bt = {m_bt[0], btn_rst_n};
      m_e.pr  = (m_st == 0);
      m_e.cr  = (m_st == 3);
      m_e.st  = m_st[1:0];
      m_e.cnt = m_lost[7:0];
      sb_q.push_back(m_e);
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_vec = n_vec + 1;
      if ({pll_reset, cpu_rst_n, rst_state, lock_lost_cnt} !== mon_e) begin
        n_err = n_err + 1;
        $display("FAIL cycle t=%0t got pr=%b cr=%b st=%b cnt=%0d exp pr=%b cr=%b st=%b cnt=%0d",
                 $time, pll_reset, cpu_rst_n, rst_state, lock_lost_cnt,
                 mon_e.pr, mon_e.cr, mon_e.st, mon_e.cnt);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rst(input string name);
    n_vec = n_vec + 1;
    if ({pll_reset, cpu_rst_n, rst_state, lock_lost_cnt} !== 12'b1_0_00_00000000) begin
      n_err = n_err + 1;
      $display("FAIL %s got pr=%b cr=%b st=%b cnt=%0d exp pr=1 cr=0 st=00 cnt=0",
               name, pll_reset, cpu_rst_n, rst_state, lock_lost_cnt);
    end
  endtask

  task automatic wait_st(input logic [1:0] s, input int budget);
    int k;
    k = 0;
    while (rst_state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rst_state !== s) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL wait_state got=%b exp=%b after %0d cycles", rst_state, s, budget);
    end
  endtask

  initial begin
    pll_lock = 1'b1;
    #12;
    check_rst("por_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_st(2'b11, 60);

    // lock held low: repeated PLL reset / timeout cycles
    pll_lock = 1'b0;
    cyc(200);

    // lock glitch while qualifying
    wait_st(2'b01, 100);
    pll_lock = 1'b1; cyc(5);
    pll_lock = 1'b0; cyc(1);
    pll_lock = 1'b1;
    wait_st(2'b11, 200);

    // two lock losses in RUN
    repeat (2) begin
      cyc(5);
      pll_lock = 1'b0; cyc(2);
      pll_lock = 1'b1;
      wait_st(2'b11, 200);
    end

    // short button glitch, then a real press
    btn_rst_n = 1'b0; cyc(2);
    btn_rst_n = 1'b1; cyc(10);
    btn_rst_n = 1'b0; cyc(10);
    btn_rst_n = 1'b1;
    wait_st(2'b11, 100);

    // button request coinciding with lock loss
    cyc(3);
    btn_rst_n = 1'b0; cyc(3);
    pll_lock  = 1'b0; cyc(4);
    btn_rst_n = 1'b1;
    pll_lock  = 1'b1;
    wait_st(2'b11, 200);

    // randomized phases
    repeat (60) begin
      case ($urandom_range(0, 3))
        0: begin pll_lock = 1'b0; cyc($urandom_range(1, 6)); pll_lock = 1'b1; end
        1: begin btn_rst_n = 1'b0; cyc($urandom_range(1, 12)); btn_rst_n = 1'b1; end
        2: begin
          btn_rst_n = $urandom_range(0, 1) == 0;
          pll_lock  = $urandom_range(0, 3) != 0;
          cyc($urandom_range(1, 8));
          btn_rst_n = 1'b1;
          pll_lock  = 1'b1;
        end
        default: cyc($urandom_range(1, 40));
      endcase
      cyc($urandom_range(0, 30));
    end
    pll_lock  = 1'b1;
    btn_rst_n = 1'b1;
    wait_st(2'b11, 300);

    // saturate the lock-loss counter
    repeat (300) begin
      pll_lock = 1'b1;
      wait_st(2'b11, 200);
      pll_lock = 1'b0;
      cyc(3);
    end
    pll_lock = 1'b1;
    wait_st(2'b11, 200);
    n_vec = n_vec + 1;
    if (lock_lost_cnt !== 8'd255) begin
      n_err = n_err + 1;
      $display("FAIL lost_cnt_saturate got=%0d exp=255", lock_lost_cnt);
    end

    // asynchronous reset in the middle of HOLD
    btn_rst_n = 1'b0;
    wait_st(2'b10, 50);
    cyc(2);
    #2 rst_n = 1'b0;
    #1 check_rst("async_mid_hold");
    btn_rst_n = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    wait_st(2'b11, 100);
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
